serial_word_receiver: RTL and testbench

//  Deserializer for the serial stream produced by the team's right-shifting shift register.
//  - Collects WORD_WIDTH bits LSB-first after a startFrame pulse and assembles a parallel word.
//  - Presents the word on a valid/ready output stage with a holding register, so the next frame
//    can be received while the previous word waits; sits between serial links and word consumers.

---
 rtl/serial_rx_pkg.sv | 13 +
 rtl/serial_rx_holding_stage.sv | 50 +++++
 rtl/serial_word_receiver.sv | 147 ++++++++++++++
 tb/tb_serial_word_receiver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial word receiver: FSM state encoding and parity sense.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rxState_t;

  // XOR over data bits plus parity bit must equal this value for a good frame.
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/serial_rx_holding_stage.sv
// Holding register with valid/ready handshake; a word offered while the register is full and
// not being consumed is dropped and flagged as a sticky overrun.
module serial_rx_holding_stage #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  loadRequest,
  input  logic [WORD_WIDTH-1:0] loadWord,
  input  logic                  wordReady,
  input  logic                  clearErrors,
  output logic                  wordValid,
  output logic [WORD_WIDTH-1:0] parallelOutput,
  output logic                  overrunError
);

  logic wordValidReg;
  logic [WORD_WIDTH-1:0] holdReg;
  logic overrunReg;
  logic canLoad;

  // Free when empty, or when the current word leaves on this very edge.
  assign canLoad = !wordValidReg || wordReady;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      wordValidReg <= 1'b0;
      holdReg      <= '0;
      overrunReg   <= 1'b0;
    end else begin
      if (loadRequest && canLoad) begin
        holdReg      <= loadWord;
        wordValidReg <= 1'b1;
      end else if (wordValidReg && wordReady) begin
        wordValidReg <= 1'b0;
      end

      if (loadRequest && !canLoad) begin
        overrunReg <= 1'b1;
      end else if (clearErrors) begin
        overrunReg <= 1'b0;
      end
    end
  end

  assign wordValid      = wordValidReg;
  assign parallelOutput = holdReg;
  assign overrunError   = overrunReg;

endmodule

// File: rtl/serial_word_receiver.sv
// LSB-first serial-to-parallel receiver feeding a valid/ready holding stage.
// Define SERIAL_RX_PARITY_EN to append and check an even-parity bit after each data word.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  enable,
  input  logic                  startFrame,
  input  logic                  serialValid,
  input  logic                  serialInput,
  input  logic                  wordReady,
  input  logic                  clearErrors,
  output logic                  wordValid,
  output logic [WORD_WIDTH-1:0] parallelOutput,
  output logic                  busy,
  output logic                  overrunError,
  output logic                  parityError
);

  localparam int COUNT_WIDTH = $clog2(WORD_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(WORD_WIDTH - 1);

  rxState_t stateReg, stateNext;
  logic [COUNT_WIDTH-1:0] bitCountReg, bitCountNext;
  logic [WORD_WIDTH-1:0]  shiftReg, shiftNext, shiftedWord;
  logic                   loadRequest;
  logic [WORD_WIDTH-1:0]  loadWord;

  // Right shift with the incoming bit entering at the MSB.
  generate
    for (genvar gi = 0; gi < WORD_WIDTH - 1; gi++) begin : gShift
      assign shiftedWord[gi] = shiftReg[gi+1];
    end
  endgenerate
  assign shiftedWord[WORD_WIDTH-1] = serialInput;

`ifdef SERIAL_RX_PARITY_EN
  logic parityFail;
  logic parityErrorReg;
`endif

  always_comb begin
    stateNext    = stateReg;
    bitCountNext = bitCountReg;
    shiftNext    = shiftReg;
    loadRequest  = 1'b0;
    loadWord     = shiftedWord;
`ifdef SERIAL_RX_PARITY_EN
    parityFail   = 1'b0;
`endif
    if (enable) begin
      case (stateReg)
        IDLE: begin
          if (startFrame) begin
            stateNext    = SHIFT;
            bitCountNext = '0;
          end
        end
        SHIFT: begin
          if (serialValid && bitCountReg == LAST_BIT) begin
            shiftNext    = shiftedWord;
            bitCountNext = '0;
`ifdef SERIAL_RX_PARITY_EN
            // Data is not yet a complete frame, so startFrame simply restarts.
            stateNext    = startFrame ? SHIFT : PARITY;
`else
            loadRequest  = 1'b1;
            stateNext    = startFrame ? SHIFT : IDLE;
`endif
          end else if (startFrame) begin
            bitCountNext = '0;
          end else if (serialValid) begin
            shiftNext    = shiftedWord;
            bitCountNext = bitCountReg + COUNT_WIDTH'(1);
          end
        end
        PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
          if (serialValid) begin
            if (((^shiftReg) ^ serialInput) == PARITY_EVEN) begin
              loadRequest = 1'b1;
              loadWord    = shiftReg;
            end else begin
              parityFail  = 1'b1;
            end
            stateNext    = startFrame ? SHIFT : IDLE;
            bitCountNext = '0;
          end else if (startFrame) begin
            stateNext    = SHIFT;
            bitCountNext = '0;
          end
`else
          stateNext = IDLE;
`endif
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      stateReg    <= IDLE;
      bitCountReg <= '0;
      shiftReg    <= '0;
    end else begin
      stateReg    <= stateNext;
      bitCountReg <= bitCountNext;
      shiftReg    <= shiftNext;
    end
  end

  assign busy = (stateReg != IDLE);

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clock) begin
    if (!resetN) begin
      parityErrorReg <= 1'b0;
    end else if (parityFail) begin
      parityErrorReg <= 1'b1;
    end else if (clearErrors) begin
      parityErrorReg <= 1'b0;
    end
  end
  assign parityError = parityErrorReg;
`else
  assign parityError = 1'b0;
`endif

  serial_rx_holding_stage #(
    .WORD_WIDTH(WORD_WIDTH)
  ) holdingStage (
    .clock         (clock),
    .resetN        (resetN),
    .loadRequest   (loadRequest),
    .loadWord      (loadWord),
    .wordReady     (wordReady),
    .clearErrors   (clearErrors),
    .wordValid     (wordValid),
    .parallelOutput(parallelOutput),
    .overrunError  (overrunError)
  );

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WORD_WIDTH=16); parity steps follow SERIAL_RX_PARITY_EN.
module tb_serial_word_receiver;

  logic        clock = 1'b0;
  logic        resetN, enable, startFrame, serialValid, serialInput, wordReady, clearErrors;
  logic        wordValid, busy, overrunError, parityError;
  logic [15:0] parallelOutput;

  int testsRun  = 0;
  int failCount = 0;

  serial_word_receiver #(.WORD_WIDTH(16)) dut (
    .clock         (clock),
    .resetN        (resetN),
    .enable        (enable),
    .startFrame    (startFrame),
    .serialValid   (serialValid),
    .serialInput   (serialInput),
    .wordReady     (wordReady),
    .clearErrors   (clearErrors),
    .wordValid     (wordValid),
    .parallelOutput(parallelOutput),
    .busy          (busy),
    .overrunError  (overrunError),
    .parityError   (parityError)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sendBit(input logic b);
    serialInput = b;
    serialValid = 1'b1;
    step();
    serialValid = 1'b0;
  endtask

  // Optional start pulse, then data bits 0..n-1.
  task automatic sendHead(input logic [15:0] w, input int n, input logic withStart);
    if (withStart) begin
      startFrame = 1'b1;
      step();
      startFrame = 1'b0;
    end
    for (int i = 0; i < n; i++) sendBit(w[i]);
  endtask

  // Last data bit (and parity bit when enabled); startOnLast raises startFrame on the final bit.
  task automatic sendTail(input logic [15:0] w, input logic pbit, input logic startOnLast);
    serialInput = w[15];
    serialValid = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
    step();
    serialInput = pbit;
`endif
    startFrame = startOnLast;
    step();
    startFrame  = 1'b0;
    serialValid = 1'b0;
  endtask

  task automatic sendFrame(input logic [15:0] w);
    sendHead(w, 15, 1'b1);
    sendTail(w, ^w, 1'b0);
    $display("[TB] frame %h sent: wordValid=%0b word=%h overrun=%0b", w, wordValid, parallelOutput,
             overrunError);
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b1; startFrame = 1'b0; serialValid = 1'b0;
    serialInput = 1'b0; wordReady = 1'b1; clearErrors = 1'b0;
    step();
    step();
    check("reset wordValid", 32'(wordValid), 32'h0);
    check("reset data", 32'(parallelOutput), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset overrun", 32'(overrunError), 32'h0);
    check("reset parityErr", 32'(parityError), 32'h0);
    resetN = 1'b1;
    step();

    // 1: single frame, latency and one-cycle valid
    sendHead(16'hA5C3, 15, 1'b1);
    check("t1 valid before last", 32'(wordValid), 32'h0);
    check("t1 busy mid", 32'(busy), 32'h1);
    sendTail(16'hA5C3, ^16'hA5C3, 1'b0);
    $display("[TB] t1 frame a5c3: wordValid=%0b word=%h", wordValid, parallelOutput);
    check("t1 valid", 32'(wordValid), 32'h1);
    check("t1 data", 32'(parallelOutput), 32'hA5C3);
    check("t1 busy after", 32'(busy), 32'h0);
    step();
    check("t1 valid one cycle", 32'(wordValid), 32'h0);

    // 2: overrun while the first word is held
    wordReady = 1'b0;
    sendFrame(16'h1234);
    check("t2 first valid", 32'(wordValid), 32'h1);
    check("t2 first data", 32'(parallelOutput), 32'h1234);
    check("t2 no overrun yet", 32'(overrunError), 32'h0);
    sendFrame(16'h5678);
    check("t2 held data", 32'(parallelOutput), 32'h1234);
    check("t2 still valid", 32'(wordValid), 32'h1);
    check("t2 overrun", 32'(overrunError), 32'h1);
    wordReady = 1'b1;
    step();
    check("t2 consumed", 32'(wordValid), 32'h0);
    check("t2 overrun sticky", 32'(overrunError), 32'h1);
    clearErrors = 1'b1;
    step();
    clearErrors = 1'b0;
    check("t2 overrun cleared", 32'(overrunError), 32'h0);

    // 2b: full register consumed on the same edge a new word loads
    wordReady = 1'b0;
    sendFrame(16'h1111);
    sendHead(16'h2222, 15, 1'b1);
    wordReady = 1'b1;
    sendTail(16'h2222, ^16'h2222, 1'b0);
    check("t2b replace data", 32'(parallelOutput), 32'h2222);
    check("t2b replace valid", 32'(wordValid), 32'h1);
    check("t2b no overrun", 32'(overrunError), 32'h0);
    step();

    // 3: serialValid gaps and enable low with bogus bits offered
    startFrame = 1'b1;
    step();
    startFrame = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 1) step();
      if (i == 8) begin
        enable = 1'b0;
        serialValid = 1'b1;
        serialInput = ~serialInput;
        step(); step(); step();
        serialValid = 1'b0;
        check("t3 busy frozen", 32'(busy), 32'h1);
        check("t3 no word frozen", 32'(wordValid), 32'h0);
        enable = 1'b1;
      end
      sendBit(16'h3C5A >> i);
    end
    sendTail(16'h3C5A, ^16'h3C5A, 1'b0);
    $display("[TB] t3 gapped frame 3c5a: wordValid=%0b word=%h", wordValid, parallelOutput);
    check("t3 valid", 32'(wordValid), 32'h1);
    check("t3 data", 32'(parallelOutput), 32'h3C5A);
    step();

    // 4: restart after 7 bits
    sendHead(16'h0000, 7, 1'b1);
    sendFrame(16'hFFFF);
    check("t4 data", 32'(parallelOutput), 32'hFFFF);
    check("t4 valid", 32'(wordValid), 32'h1);
    check("t4 overrun", 32'(overrunError), 32'h0);
    check("t4 parityErr", 32'(parityError), 32'h0);
    step();

    // 5: reset mid-frame with a word pending
    wordReady = 1'b0;
    sendFrame(16'h00FF);
    check("t5 pending", 32'(wordValid), 32'h1);
    sendHead(16'h0F0F, 5, 1'b1);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    check("t5 rst valid", 32'(wordValid), 32'h0);
    check("t5 rst data", 32'(parallelOutput), 32'h0);
    check("t5 rst busy", 32'(busy), 32'h0);
    for (int i = 0; i < 17; i++) sendBit(1'b1);
    check("t5 no word", 32'(wordValid), 32'h0);
    check("t5 idle", 32'(busy), 32'h0);
    wordReady = 1'b1;

    // 7: startFrame on the completing bit restarts while the word is delivered
    sendHead(16'hBEEF, 15, 1'b1);
    sendTail(16'hBEEF, ^16'hBEEF, 1'b1);
    check("t7 data", 32'(parallelOutput), 32'hBEEF);
    check("t7 busy stays", 32'(busy), 32'h1);
    sendHead(16'h4321, 15, 1'b0);
    sendTail(16'h4321, ^16'h4321, 1'b0);
    $display("[TB] t7 back-to-back frame 4321: wordValid=%0b word=%h", wordValid, parallelOutput);
    check("t7 second data", 32'(parallelOutput), 32'h4321);
    check("t7 second valid", 32'(wordValid), 32'h1);
    step();

`ifdef SERIAL_RX_PARITY_EN
    // 6: parity good and bad
    sendHead(16'h0001, 15, 1'b1);
    sendTail(16'h0001, 1'b1, 1'b0);
    check("t6 good valid", 32'(wordValid), 32'h1);
    check("t6 good data", 32'(parallelOutput), 32'h0001);
    check("t6 good no err", 32'(parityError), 32'h0);
    step();
    sendHead(16'h0001, 15, 1'b1);
    sendTail(16'h0001, 1'b0, 1'b0);
    check("t6 bad no word", 32'(wordValid), 32'h0);
    check("t6 bad err", 32'(parityError), 32'h1);
    clearErrors = 1'b1;
    step();
    clearErrors = 1'b0;
    check("t6 err cleared", 32'(parityError), 32'h0);
`else
    check("t6 parityErr tied", 32'(parityError), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
